// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file and its read ports.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One registered read port: storage mux, write-first bypass and output flops.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rd_en_i,
  input  logic [ADDR_W-1:0]             rd_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs_i,
  input  logic [DEPTH-1:0]              pend_i,
  input  logic                          wr_act_i,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          rd_valid_o,
  output logic                          rd_pend_o
);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_hit_c;

  // Next-state: a same-cycle write to the read address wins and clears the pending view.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_pend_d  = rd_pend_q;
    rd_valid_d = 1'b0;
    wr_hit_c   = wr_act_i && (wr_addr_i == rd_addr_i);
    if (rd_en_i) begin
      rd_valid_d = 1'b1;
      if (wr_hit_c) begin
        rd_data_d = wr_data_i;
        rd_pend_d = 1'b0;
      end else begin
        rd_data_d = regs_i[rd_addr_i];
        rd_pend_d = pend_i[rd_addr_i];
      end
    end
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_pend_o  = rd_pend_q;

endmodule : regfile_rdport

// File: rtl/mips_regfile.sv
// MIPS-style register file with per-register pending scoreboard and N read ports.
module mips_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [(2**ADDR_W)-1:0]     pend_vec
);

  localparam int unsigned RF_DEPTH = 2 ** ADDR_W;
  localparam logic        ZERO_EN  = (ZERO_REG != 0);

  logic [RF_DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [RF_DEPTH-1:0]             pend_q, pend_d;
  logic                            wr_act_c;
  logic                            iss_act_c;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  always_comb begin
    wr_act_c  = wr_en  && !(ZERO_EN && (wr_addr  == '0));
    iss_act_c = iss_en && !(ZERO_EN && (iss_addr == '0));
  end

  // Next-state storage and scoreboard: write clears pending, a same-cycle issue sets it again.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_act_c) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (iss_act_c) begin
      pend_d[iss_addr] = 1'b1;
    end
  end

  // Storage and pending state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;

  // One independent read port per requested slot.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rdport
    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (RF_DEPTH)
    ) u_rdport (
      .clock      (clock),
      .reset      (reset),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
      .regs_i     (regs_q),
      .pend_i     (pend_q),
      .wr_act_i   (wr_act_c),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[p]),
      .rd_pend_o  (rd_pend[p])
    );
  end

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed scenarios plus random traffic vs a behavioural model.
module tb_mips_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned DEPTH  = 32;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]         rd_valid;
  logic [NUM_RD-1:0]         rd_pend;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      iss_en;
  logic [ADDR_W-1:0]         iss_addr;
  logic [DEPTH-1:0]          pend_vec;

  mips_regfile #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_pend  (rd_pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_vec (pend_vec)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural registers, scoreboard and expected port outputs.
  logic [DATA_W-1:0] m_mem   [DEPTH];
  logic              m_pend  [DEPTH];
  logic [DATA_W-1:0] e_data  [NUM_RD];
  logic              e_valid [NUM_RD];
  logic              e_pend  [NUM_RD];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      e_data[p]  = '0;
      e_valid[p] = 1'b0;
      e_pend[p]  = 1'b0;
    end
  endtask

  function automatic logic [DEPTH-1:0] model_pend_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic idle();
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic set_read(input int p, input logic en, input logic [ADDR_W-1:0] a);
    rd_en[p] = en;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  // Apply one clock edge to DUT and model. Register 0 is the constant zero; writes happen
  // before reads; a read sees the scoreboard as it was before the edge, minus any register
  // being written in the same cycle.
  task automatic step();
    logic             pend_before [DEPTH];
    logic             wrote;
    logic [ADDR_W-1:0] a;
    if (reset) begin
      model_clear();
    end else begin
      pend_before = m_pend;
      wrote = wr_en && (wr_addr != 0);
      if (wrote) begin
        m_mem[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (iss_en && (iss_addr != 0)) m_pend[iss_addr] = 1'b1;
      for (int p = 0; p < NUM_RD; p++) begin
        e_valid[p] = rd_en[p];
        if (rd_en[p]) begin
          a = rd_addr[p*ADDR_W +: ADDR_W];
          e_data[p] = m_mem[a];
          e_pend[p] = pend_before[a] && !(wrote && (wr_addr == a));
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_clear();
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=00", rd_valid); end
    checks++; if (rd_pend !== '0) begin errors++; $display("FAIL reset_rd_pend got=%b exp=00", rd_pend); end
    checks++; if (pend_vec !== '0) begin errors++; $display("FAIL reset_pend_vec got=%h exp=0", pend_vec); end
    // Activity while reset is held must have no effect.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAA;
    iss_en = 1'b1; iss_addr = 5'd4;
    set_read(0, 1'b1, 5'd4); set_read(1, 1'b1, 5'd4);
    step();
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_hold_valid got=%b exp=00", rd_valid); end
    checks++; if (pend_vec !== '0) begin errors++; $display("FAIL reset_hold_pend_vec got=%h exp=0", pend_vec); end
    reset = 1'b0;
    idle();
    set_read(0, 1'b1, 5'd4);
    step();
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL reset_ignored_write got=%h exp=0", rd_data[31:0]); end
    checks++; if (rd_pend[0] !== 1'b0) begin errors++; $display("FAIL reset_ignored_issue got=%b exp=0", rd_pend[0]); end
  endtask

  task automatic test_reset_read();
    idle();
    set_read(0, 1'b1, 5'd1); set_read(1, 1'b1, 5'd2);
    step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL post_reset_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL post_reset_valid got=%b exp=11", rd_valid); end
    checks++; if (rd_pend !== 2'b00) begin errors++; $display("FAIL post_reset_pend got=%b exp=00", rd_pend); end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'd20; step();
    idle(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd30; step();
    idle(); set_read(0, 1'b1, 5'd1); set_read(1, 1'b1, 5'd2); step();
    checks++; if (rd_data[31:0] !== 32'd20) begin errors++; $display("FAIL write_read_r1 got=%0d exp=20", rd_data[31:0]); end
    checks++; if (rd_data[63:32] !== 32'd30) begin errors++; $display("FAIL write_read_r2 got=%0d exp=30", rd_data[63:32]); end
    checks++; if (rd_valid !== 2'b11) begin errors++; $display("FAIL write_read_valid got=%b exp=11", rd_valid); end
  endtask

  task automatic test_bypass();
    idle(); iss_en = 1'b1; iss_addr = 5'd5; step();
    checks++; if (pend_vec[5] !== 1'b1) begin errors++; $display("FAIL issue_r5_pend got=%b exp=1", pend_vec[5]); end
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_read(0, 1'b1, 5'd5); step();
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got=%h exp=deadbeef", rd_data[31:0]); end
    checks++; if (rd_pend[0] !== 1'b0) begin errors++; $display("FAIL bypass_pend got=%b exp=0", rd_pend[0]); end
    checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL bypass_valid got=%b exp=01", rd_valid); end
    checks++; if (pend_vec[5] !== 1'b0) begin errors++; $display("FAIL write_clears_pend got=%b exp=0", pend_vec[5]); end
  endtask

  task automatic test_issue();
    idle(); iss_en = 1'b1; iss_addr = 5'd7; step();
    idle(); set_read(1, 1'b1, 5'd7); step();
    checks++; if (rd_pend[1] !== 1'b1) begin errors++; $display("FAIL issue_read_pend got=%b exp=1", rd_pend[1]); end
    idle(); iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd9; step();
    checks++; if (pend_vec[7] !== 1'b1) begin errors++; $display("FAIL issue_wins_pend got=%b exp=1", pend_vec[7]); end
    idle(); set_read(0, 1'b1, 5'd7); set_read(1, 1'b1, 5'd7); step();
    checks++; if (rd_data[31:0] !== 32'd9) begin errors++; $display("FAIL issue_write_data p0 got=%0d exp=9", rd_data[31:0]); end
    checks++; if (rd_data[63:32] !== 32'd9) begin errors++; $display("FAIL same_addr_data p1 got=%0d exp=9", rd_data[63:32]); end
    checks++; if (rd_pend !== 2'b11) begin errors++; $display("FAIL issue_write_rd_pend got=%b exp=11", rd_pend); end
  endtask

  task automatic test_zero_reg();
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h55; iss_en = 1'b1; iss_addr = 5'd0;
    set_read(0, 1'b1, 5'd0);
    step();
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL zero_bypass_data got=%h exp=0", rd_data[31:0]); end
    checks++; if (pend_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_pend_vec got=%b exp=0", pend_vec[0]); end
    idle(); set_read(0, 1'b1, 5'd0); set_read(1, 1'b1, 5'd0); step();
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL zero_read_data got=%h exp=0", rd_data); end
    checks++; if (rd_pend !== 2'b00) begin errors++; $display("FAIL zero_read_pend got=%b exp=00", rd_pend); end
  endtask

  task automatic test_hold();
    idle(); set_read(0, 1'b1, 5'd1); set_read(1, 1'b1, 5'd2); step();
    idle(); step();
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL hold_valid got=%b exp=00", rd_valid); end
    checks++; if (rd_data !== {32'd30, 32'd20}) begin errors++; $display("FAIL hold_data got=%h exp=%h", rd_data, {32'd30, 32'd20}); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int n = 0; n < 400; n++) begin
      idle();
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = ADDR_W'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = ADDR_W'($urandom_range(0, 7));
      for (int p = 0; p < NUM_RD; p++) begin
        a = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 31));
        set_read(p, 1'($urandom_range(0, 1)), a);
      end
      step();
      for (int p = 0; p < NUM_RD; p++) begin
        checks++;
        if (rd_data[p*DATA_W +: DATA_W] !== e_data[p]) begin
          errors++; $display("FAIL rand_data cyc=%0d p=%0d got=%h exp=%h", n, p, rd_data[p*DATA_W +: DATA_W], e_data[p]);
        end
        checks++;
        if (rd_valid[p] !== e_valid[p]) begin
          errors++; $display("FAIL rand_valid cyc=%0d p=%0d got=%b exp=%b", n, p, rd_valid[p], e_valid[p]);
        end
        checks++;
        if (rd_pend[p] !== e_pend[p]) begin
          errors++; $display("FAIL rand_pend cyc=%0d p=%0d got=%b exp=%b", n, p, rd_pend[p], e_pend[p]);
        end
      end
      checks++;
      if (pend_vec !== model_pend_vec()) begin
        errors++; $display("FAIL rand_pend_vec cyc=%0d got=%h exp=%h", n, pend_vec, model_pend_vec());
      end
    end
  endtask

  task automatic test_reset_mid_read();
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234; iss_en = 1'b1; iss_addr = 5'd9; step();
    idle(); set_read(0, 1'b1, 5'd3); step();
    checks++; if (rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL r3_loaded got=%h exp=1234", rd_data[31:0]); end
    // Keep a read in flight, then hit reset between clock edges.
    set_read(0, 1'b1, 5'd3); set_read(1, 1'b1, 5'd3);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL async_reset_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL async_reset_valid got=%b exp=00", rd_valid); end
    checks++; if (pend_vec !== '0) begin errors++; $display("FAIL async_reset_pend_vec got=%h exp=0", pend_vec); end
    @(posedge clock); #1;
    reset = 1'b0;
    idle(); set_read(0, 1'b1, 5'd3); step();
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL r3_after_reset got=%h exp=0", rd_data[31:0]); end
    checks++; if (rd_valid !== 2'b01) begin errors++; $display("FAIL r3_after_reset_valid got=%b exp=01", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_reset_read();
    test_write_read();
    test_bypass();
    test_issue();
    test_zero_reg();
    test_hold();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mips_regfile

// File: doc/mips_regfile.md
MIPS_REGFILE -- requirements
Module: mips_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rd_en  input  NUM_RD  per-port read request.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  per-port read address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  per-port registered read data, packed the same way.
REQ-010 rd_valid  output  NUM_RD  per-port flag: rd_data was updated by the previous cycle's request.
REQ-011 rd_pend  output  NUM_RD  per-port flag: the register read was pending (scoreboarded) at request time.
REQ-012 wr_en  input  1  write-back strobe.
REQ-013 wr_addr  input  ADDR_W  write-back address.
REQ-014 wr_data  input  DATA_W  write-back data.
REQ-015 iss_en  input  1  issue strobe; marks iss_addr as pending.
REQ-016 iss_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-017 pend_vec  output  2**ADDR_W  current pending bit of every register.

Function
REQ-018 Read latency: exactly 1 cycle; rd_en[p] at edge N gives rd_data[p], rd_valid[p] and rd_pend[p] valid after edge N.
REQ-019 With rd_en[p]=0: rd_data[p] and rd_pend[p] hold their value; rd_valid[p] deasserts after the next edge.
REQ-020 Write: wr_en=1 stores wr_data into wr_addr at the edge and clears that register's pending bit.
REQ-021 Write-first bypass: a same-cycle read of wr_addr returns wr_data; rd_pend reports 0 for that read.
REQ-022 Multiple read ports may address the same register in the same cycle; each returns identical data.
REQ-023 Issue: iss_en=1 sets the pending bit of iss_addr at the edge.
REQ-024 Same-cycle iss_en and wr_en to one address: the pending bit ends at 1 (set wins); data is still written.
REQ-025 rd_pend reflects the pending bit before the edge, after the REQ-021 bypass is applied; same-cycle issue does not affect it.
REQ-026 ZERO_REG=1: writes to address 0 are discarded, issues to address 0 are ignored, reads of 0 return 0, and pend_vec[0] is constantly 0.
REQ-027 ZERO_REG=0: register 0 behaves like every other register.
REQ-028 Only wr_en writes; read requests never alter storage.

Reset
REQ-029 reset asserted: all registers are 0, all pending bits are 0, and rd_data, rd_valid and rd_pend are 0, immediately and without a clock edge.
REQ-030 While reset is high, wr_en, iss_en and rd_en are ignored.
REQ-031 The first edge after reset deasserts operates normally; an in-flight read is discarded (rd_valid 0).

Structure
REQ-032 Shared package regfile_pkg holds the default DATA_W, ADDR_W and NUM_RD constants and the localparam DEPTH = 2**ADDR_W.
REQ-033 One sub-module, regfile_rdport, implements a single read port (mux, bypass, output registers); it is instantiated NUM_RD times by a generate loop.
REQ-034 Storage and the pending vector reside in mips_regfile; no vendor RAM primitive is used.

Verification
REQ-035 Reset, then read addresses 1 and 2 -> next cycle rd_data is 0 and 0, rd_valid=11, rd_pend=00.
REQ-036 Write 20 to r1 and 30 to r2 on consecutive cycles, then read r1 and r2 -> 20 and 30 after 1 cycle.
REQ-037 Write 0xDEADBEEF to r5 while port 0 reads r5 in the same cycle -> rd_data[0]=0xDEADBEEF and rd_pend[0]=0.
REQ-038 Issue r7, read r7 -> rd_pend=1; same-cycle iss r7 and wr r7 with 9 -> pend_vec[7]=1 and a read returns 9.
REQ-039 ZERO_REG=1: write 0x55 to r0 and issue r0, then read r0 -> rd_data=0, pend_vec[0]=0.
REQ-040 Assert reset mid-read after loading r3=0x1234 -> outputs 0 asynchronously, and a read of r3 after release returns 0.
